// File: rtl/writeback_stage_pkg.sv
// Shared pipeline package: widths, register count
// and the writeback latch bundle.
package writeback_stage_pkg;

  localparam int NUM_REGS     = 8;
  localparam int IDX_W        = 3;
  localparam int DATA_W       = 32;
  localparam int CNT_W        = 2;
  localparam int SRC2_MUX_BIT = 6;

  typedef struct packed {
    logic              v;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wb_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters, saturation
// error tracking and RAW-hazard stall generation.
module wb_scoreboard
  import writeback_stage_pkg::*;
#(
  parameter int NR     = NUM_REGS,
  parameter int IW     = IDX_W,
  parameter int CW     = CNT_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic          issue_valid,
  input  logic          issue_we,
  input  logic [IW-1:0] issue_dst,
  input  logic [IW-1:0] src1_idx,
  input  logic [IW-1:0] src2_idx,
  input  logic          src2_is_imm,
  output logic          RR_stall,
  output logic          sb_err
);

  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q [NR];
  logic [CW-1:0] cnt_d [NR];
  logic          sb_err_q, sb_err_d;
  logic [NR-1:0] hz;
  logic          issue_fire;

  // A pending write whose last commit is on the bus
  // this cycle is already visible through the regfile.
  always_comb begin
    hz = '0;
    for (int r = 0; r < NR; r++) begin
      hz[r] = (cnt_q[r] != '0) &&
              !(BYPASS && (cnt_q[r] == ONE) &&
                we && (widx == IW'(r)));
    end
  end

  // Hazard uses pre-increment counts, so rd==rs works.
  always_comb begin
    RR_stall = issue_valid &
               (hz[src1_idx] |
                (~src2_is_imm & hz[src2_idx]) |
                (issue_we & (cnt_q[issue_dst] == CMAX)));
    issue_fire = issue_valid & issue_we & ~RR_stall;
  end

  // Counter update; over/underflow holds and flags.
  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < NR; r++) begin
      logic inc, dec;
      inc      = issue_fire && (issue_dst == IW'(r));
      dec      = we && (widx == IW'(r));
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        if (cnt_q[r] == CMAX) sb_err_d = 1'b1;
        else cnt_d[r] = cnt_q[r] + ONE;
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0) sb_err_d = 1'b1;
        else cnt_d[r] = cnt_q[r] - ONE;
      end
    end
  end

  // Counter and sticky error state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NR; r++) cnt_q[r] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NR; r++) cnt_q[r] <= cnt_d[r];
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: latches EX results, drives the
// regfile write port and hosts the hazard scoreboard.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic [IDX_W-1:0]  ex_dst_idx,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [IDX_W-1:0]  issue_dst,
  input  logic [IDX_W-1:0]  src1_idx,
  input  logic [IDX_W-1:0]  src2_idx,
  input  logic              src2_is_imm,
  output logic              we,
  output logic [DATA_W-1:0] wdata,
  output logic [IDX_W-1:0]  widx,
  output logic              RR_stall,
  output logic              sb_err
);

  wb_t wb_q, wb_d;

  // Data and index hold when no write retires.
  always_comb begin
    wb_d   = wb_q;
    wb_d.v = ex_valid & ex_we;
    if (ex_valid & ex_we) begin
      wb_d.idx  = ex_dst_idx;
      wb_d.data = ex_result;
    end
  end

  // Single-cycle EX-to-regfile latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_q <= '0;
    else      wb_q <= wb_d;
  end

  assign we    = wb_q.v;
  assign wdata = wb_q.data;
  assign widx  = wb_q.idx;

  wb_scoreboard #(
    .NR     (NUM_REGS),
    .IW     (IDX_W),
    .CW     (CNT_W),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .we          (wb_q.v),
    .widx        (wb_q.idx),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_dst   (issue_dst),
    .src1_idx    (src1_idx),
    .src2_idx    (src2_idx),
    .src2_is_imm (src2_is_imm),
    .RR_stall    (RR_stall),
    .sb_err      (sb_err)
  );

endmodule
